// File: rtl/sm_ldm_pkg.sv
// rtl/sm_ldm_pkg.sv - shared types and constants for the LDM/STM sequencer
package sm_ldm_pkg;

    // Bytes per transferred word; addresses step by this amount per beat.
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        WB    = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Encoding is {pre_index, up} so the mode falls straight out of the P/U bits.
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } addr_mode_e;

    function automatic addr_mode_e addr_mode(input logic pre_index, input logic up);
        return addr_mode_e'({pre_index, up});
    endfunction

endpackage

// File: rtl/sm_reg_list_scan.sv
// rtl/sm_reg_list_scan.sv - lowest-set-bit encoder and popcount over a register list
//
// Ports:
//   list_i    register list, bit i = register i
//   any_o     at least one bit set
//   lowest_o  index of the lowest set bit (0 when list is empty)
//   count_o   number of set bits
module sm_reg_list_scan
    import sm_ldm_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int IDX_W     = $clog2(REG_COUNT),
    parameter int CNT_W     = $clog2(REG_COUNT + 1)
) (
    input  logic [REG_COUNT-1:0] list_i,
    output logic                 any_o,
    output logic [IDX_W-1:0]     lowest_o,
    output logic [CNT_W-1:0]     count_o
);

    always_comb begin
        any_o    = 1'b0;
        lowest_o = '0;
        count_o  = '0;
        // Descending walk so the last hit written is the lowest index.
        for (int i = REG_COUNT - 1; i >= 0; i--) begin
            if (list_i[i]) begin
                any_o    = 1'b1;
                lowest_o = IDX_W'(i);
            end
        end
        for (int i = 0; i < REG_COUNT; i++) begin
            count_o = count_o + CNT_W'(list_i[i]);
        end
    end

endmodule

// File: rtl/sm_ldm_stm_sequencer.sv
// rtl/sm_ldm_stm_sequencer.sv - multi-cycle LDM/STM block transfer initiator
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, is_load, pre_index, up,
//   writeback, base_rn, base_addr,
//   reg_list                        operation request, latched in IDLE on start
//   busy, done                      core stall and one-cycle completion pulse
//   rf_read_adress, rf_read_data    register file read port (store data)
//   rf_write_adress, rf_write_data,
//   rf_write_enable                 register file write port (loads, base writeback)
//   pc_write, pc_value              load into the program counter
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ready, mem_rdata memory request handshake
module sm_ldm_stm_sequencer
    import sm_ldm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 16,
    parameter int IDX_W      = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_load,
    input  logic                  pre_index,
    input  logic                  up,
    input  logic                  writeback,
    input  logic [IDX_W-1:0]      base_rn,
    input  logic [DATA_WIDTH-1:0] base_addr,
    input  logic [REG_COUNT-1:0]  reg_list,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      rf_read_adress,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic [IDX_W-1:0]      rf_write_adress,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  rf_write_enable,
    output logic                  pc_write,
    output logic [DATA_WIDTH-1:0] pc_value,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int              CNT_W  = $clog2(REG_COUNT + 1);
    localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(REG_COUNT - 1);
    localparam logic [DATA_WIDTH-1:0] WORD = DATA_WIDTH'(WORD_BYTES);

    state_e                state_q, state_d;
    logic                  is_load_q, is_load_d;
    logic                  writeback_q, writeback_d;
    addr_mode_e            mode_q, mode_d;
    logic [IDX_W-1:0]      base_rn_q, base_rn_d;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic [REG_COUNT-1:0]  list_q, list_d;       // registers still to transfer
    logic                  rn_in_list_q, rn_in_list_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wb_val_q, wb_val_d;

    logic                  list_any;
    logic [IDX_W-1:0]      cur_idx;
    logic [CNT_W-1:0]      list_cnt;
    logic [REG_COUNT-1:0]  cur_onehot;
    logic [DATA_WIDTH-1:0] span;
    logic [DATA_WIDTH-1:0] first_addr;
    logic                  beat;
    logic                  last_beat;

    sm_reg_list_scan #(
        .REG_COUNT (REG_COUNT),
        .IDX_W     (IDX_W),
        .CNT_W     (CNT_W)
    ) u_scan (
        .list_i   (list_q),
        .any_o    (list_any),
        .lowest_o (cur_idx),
        .count_o  (list_cnt)
    );

    assign cur_onehot = REG_COUNT'(1) << cur_idx;
    assign beat       = (state_q == XFER) && mem_ready;
    assign last_beat  = (list_q & ~cur_onehot) == '0;
    // In SETUP list_q still holds the full list, so list_cnt is n.
    assign span       = DATA_WIDTH'(list_cnt) * WORD;

    // The lowest register always sits at the lowest address, whatever the direction.
    always_comb begin
        first_addr = base_q;
        case (mode_q)
            MODE_IA: first_addr = base_q;
            MODE_IB: first_addr = base_q + WORD;
            MODE_DA: first_addr = base_q - span + WORD;
            MODE_DB: first_addr = base_q - span;
            default: first_addr = base_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   state_d = list_any ? XFER : DONE;
            XFER:    if (beat && last_beat) state_d = WB;
            WB:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand and address datapath
    always_comb begin
        is_load_d    = is_load_q;
        writeback_d  = writeback_q;
        mode_d       = mode_q;
        base_rn_d    = base_rn_q;
        base_d       = base_q;
        list_d       = list_q;
        rn_in_list_d = rn_in_list_q;
        addr_d       = addr_q;
        wb_val_d     = wb_val_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_load_d    = is_load;
                    writeback_d  = writeback;
                    mode_d       = addr_mode(pre_index, up);
                    base_rn_d    = base_rn;
                    base_d       = base_addr;
                    list_d       = reg_list;
                    rn_in_list_d = reg_list[base_rn];
                end
            end
            SETUP: begin
                addr_d   = first_addr;
                wb_val_d = mode_q[0] ? base_q + span : base_q - span;
            end
            XFER: begin
                if (mem_ready) begin
                    list_d = list_q & ~cur_onehot;
                    addr_d = addr_q + WORD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load_q    <= 1'b0;
            writeback_q  <= 1'b0;
            mode_q       <= MODE_DA;
            base_rn_q    <= '0;
            base_q       <= '0;
            list_q       <= '0;
            rn_in_list_q <= 1'b0;
            addr_q       <= '0;
            wb_val_q     <= '0;
        end else begin
            is_load_q    <= is_load_d;
            writeback_q  <= writeback_d;
            mode_q       <= mode_d;
            base_rn_q    <= base_rn_d;
            base_q       <= base_d;
            list_q       <= list_d;
            rn_in_list_q <= rn_in_list_d;
            addr_q       <= addr_d;
            wb_val_q     <= wb_val_d;
        end
    end

    // Outputs
    always_comb begin
        busy            = (state_q != IDLE);
        done            = 1'b0;
        rf_read_adress  = '0;
        rf_write_adress = '0;
        rf_write_data   = '0;
        rf_write_enable = 1'b0;
        pc_write        = 1'b0;
        pc_value        = '0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        case (state_q)
            XFER: begin
                mem_req  = 1'b1;
                mem_we   = !is_load_q;
                mem_addr = addr_q;
                if (!is_load_q) begin
                    rf_read_adress = cur_idx;
                    mem_wdata      = rf_read_data;
                end else if (beat) begin
                    // r15 goes through the PC path, never the register write port.
                    if (cur_idx == PC_IDX) begin
                        pc_write = 1'b1;
                        pc_value = mem_rdata;
                    end else begin
                        rf_write_enable = 1'b1;
                        rf_write_adress = cur_idx;
                        rf_write_data   = mem_rdata;
                    end
                end
            end
            WB: begin
                // A value loaded into the base register takes priority over writeback.
                if (writeback_q && !(is_load_q && rn_in_list_q)) begin
                    rf_write_enable = 1'b1;
                    rf_write_adress = base_rn_q;
                    rf_write_data   = wb_val_q;
                end
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sm_ldm_stm_sequencer.sv
// tb/tb_sm_ldm_stm_sequencer.sv - scoreboard testbench for sm_ldm_stm_sequencer
module tb_sm_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic        pre_index;
    logic        up;
    logic        writeback;
    logic [3:0]  base_rn;
    logic [31:0] base_addr;
    logic [15:0] reg_list;
    logic        busy;
    logic        done;
    logic [3:0]  rf_read_adress;
    logic [31:0] rf_read_data;
    logic [3:0]  rf_write_adress;
    logic [31:0] rf_write_data;
    logic        rf_write_enable;
    logic        pc_write;
    logic [31:0] pc_value;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    sm_ldm_stm_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .is_load         (is_load),
        .pre_index       (pre_index),
        .up              (up),
        .writeback       (writeback),
        .base_rn         (base_rn),
        .base_addr       (base_addr),
        .reg_list        (reg_list),
        .busy            (busy),
        .done            (done),
        .rf_read_adress  (rf_read_adress),
        .rf_read_data    (rf_read_data),
        .rf_write_adress (rf_write_adress),
        .rf_write_data   (rf_write_data),
        .rf_write_enable (rf_write_enable),
        .pc_write        (pc_write),
        .pc_value        (pc_value),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } rf_t;

    mem_t        exp_mem[$];
    rf_t         exp_rf[$];
    logic [31:0] exp_pc[$];
    int          exp_n[$];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          beats = 0;
    int          stalls = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: stall second beat
    bit          op_done = 1'b0;
    logic [31:0] salt = 32'h0;
    logic [31:0] rf_vals [16];

    // Register file read port and memory: loads return address XOR a per-op salt.
    assign rf_read_data = rf_vals[rf_read_adress];
    assign mem_rdata    = mem_req ? (mem_addr ^ salt) : 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: actual=%h required=none", name, act);
    endtask

    // Memory ready generator
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = 1'($urandom_range(0, 1));
                default: mem_ready = !(beats == 1 && stalls < 3);
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        logic        held_valid;
        logic [31:0] held_addr;
        logic        held_we;
        logic [31:0] held_wdata;
        mem_t        em;
        rf_t         er;
        logic [31:0] ep;
        int          en;
        int          lat;
        held_valid = 1'b0;
        held_addr  = '0;
        held_we    = 1'b0;
        held_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                held_valid = 1'b0;
                continue;
            end
            if (rf_write_enable || pc_write)
                chk("wen_pc_exclusive", 32'(rf_write_enable & pc_write), 32'h0);
            if (start && !busy) start_cyc = cyc;
            if (mem_req) begin
                if (held_valid) begin
                    chk("hold_addr", mem_addr, held_addr);
                    chk("hold_we", 32'(mem_we), 32'(held_we));
                    if (held_we) chk("hold_wdata", mem_wdata, held_wdata);
                end
                if (!mem_ready) begin
                    held_valid = 1'b1;
                    held_addr  = mem_addr;
                    held_we    = mem_we;
                    held_wdata = mem_wdata;
                    stalls++;
                end else begin
                    held_valid = 1'b0;
                    beats++;
                    if (exp_mem.size() == 0) begin
                        fail_now("unexpected_mem_beat", mem_addr);
                    end else begin
                        em = exp_mem.pop_front();
                        chk("mem_addr", mem_addr, em.addr);
                        chk("mem_we", 32'(mem_we), 32'(em.we));
                        if (em.we) chk("mem_wdata", mem_wdata, em.wdata);
                    end
                end
            end
            if (rf_write_enable) begin
                if (exp_rf.size() == 0) begin
                    fail_now("unexpected_rf_write", {28'h0, rf_write_adress});
                end else begin
                    er = exp_rf.pop_front();
                    chk("rf_write_adress", 32'(rf_write_adress), 32'(er.idx));
                    chk("rf_write_data", rf_write_data, er.data);
                end
            end
            if (pc_write) begin
                if (exp_pc.size() == 0) begin
                    fail_now("unexpected_pc_write", pc_value);
                end else begin
                    ep = exp_pc.pop_front();
                    chk("pc_value", pc_value, ep);
                end
            end
            if (done) begin
                if (exp_n.size() == 0) begin
                    fail_now("unexpected_done", 32'(cyc));
                end else begin
                    en  = exp_n.pop_front();
                    lat = (en == 0) ? 2 : en + 3 + stalls;
                    chk("done_latency", 32'(cyc - start_cyc), 32'(lat));
                end
                op_done = 1'b1;
            end
        end
    end

    // Reference model: expected beats, register writes and completion from the P/U/W rules.
    task automatic issue(input logic ld, input logic p, input logic u, input logic w,
                         input logic [3:0] rn, input logic [31:0] base, input logic [15:0] list);
        int          n;
        int          k;
        logic [31:0] span;
        logic [31:0] lo;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) rf_vals[i] = $urandom;
        salt = $urandom;
        n    = $countones(list);
        span = 32'(n) * 32'd4;
        if (u) lo = p ? base + 32'd4 : base;
        else   lo = p ? base - span : base - span + 32'd4;
        k = 0;
        for (int r = 0; r < 16; r++) begin
            if (list[r]) begin
                a = lo + 32'(k) * 32'd4;
                k++;
                if (!ld) begin
                    exp_mem.push_back('{addr: a, we: 1'b1, wdata: rf_vals[r]});
                end else begin
                    exp_mem.push_back('{addr: a, we: 1'b0, wdata: 32'h0});
                    if (r == 15) exp_pc.push_back(a ^ salt);
                    else         exp_rf.push_back('{idx: 4'(r), data: a ^ salt});
                end
            end
        end
        if (w && n != 0 && !(ld && list[rn]))
            exp_rf.push_back('{idx: rn, data: u ? base + span : base - span});
        exp_n.push_back(n);
        beats   = 0;
        stalls  = 0;
        op_done = 1'b0;
        @(posedge clk);
        #1;
        is_load   = ld;
        pre_index = p;
        up        = u;
        writeback = w;
        base_rn   = rn;
        base_addr = base;
        reg_list  = list;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic flush_and_check();
        chk("leftover_mem", 32'(exp_mem.size()), 32'h0);
        chk("leftover_rf", 32'(exp_rf.size()), 32'h0);
        chk("leftover_pc", 32'(exp_pc.size()), 32'h0);
        exp_mem.delete();
        exp_rf.delete();
        exp_pc.delete();
        exp_n.delete();
    endtask

    task automatic run_op(input logic ld, input logic p, input logic u, input logic w,
                          input logic [3:0] rn, input logic [31:0] base, input logic [15:0] list,
                          input int rmode);
        ready_mode = rmode;
        issue(ld, p, u, w, rn, base, list);
        // Noise on every request input while busy; none of it may be latched.
        for (int c = 0; c < 400 && !op_done; c++) begin
            start     = ($urandom_range(0, 3) == 0);
            is_load   = 1'($urandom);
            pre_index = 1'($urandom);
            up        = 1'($urandom);
            writeback = 1'($urandom);
            base_rn   = 4'($urandom);
            base_addr = $urandom;
            reg_list  = 16'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (!op_done) fail_now("done_timeout", 32'(cyc));
        flush_and_check();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_rf_we"}, 32'(rf_write_enable), 32'h0);
        chk({tag, "_rf_wdata"}, rf_write_data, 32'h0);
        chk({tag, "_pc_write"}, 32'(pc_write), 32'h0);
        chk({tag, "_pc_value"}, pc_value, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=%0d required=finish", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] rb;
        logic [15:0] rl;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_load   = 1'b0;
        pre_index = 1'b0;
        up        = 1'b0;
        writeback = 1'b0;
        base_rn   = 4'h0;
        base_addr = 32'h0;
        reg_list  = 16'h0;
        for (int i = 0; i < 16; i++) rf_vals[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // STMIA, base 0x1000, r0/r2/r4, writeback 0x100C to r3
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h0000_1000, 16'h0015, 0);
        // LDMDB, base 0x2000, r0/r1/pc
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'h0000_2000, 16'h8003, 0);
        // LDMIA with base in the list: loaded value wins over writeback
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 32'h0000_3000, 16'h00F2, 0);
        // Stalled second beat, store and load
        run_op(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 32'h0000_4000, 16'h0F0F, 2);
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 32'h0000_5000, 16'h0116, 2);
        // Empty list
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 32'h0000_6000, 16'h0000, 0);
        // Decrement across address zero
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0000_0004, 16'h0007, 0);
        // All sixteen registers
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 32'h0000_9000, 16'hFFFF, 1);

        // Reset in the middle of a transfer
        ready_mode = 0;
        issue(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h0000_7000, 16'h00FF);
        for (int c = 0; c < 50 && beats < 2; c++) @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        exp_mem.delete();
        exp_rf.delete();
        exp_pc.delete();
        exp_n.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 32'h0000_8000, 16'h0011, 0);

        for (int t = 0; t < 24; t++) begin
            rb = $urandom & 32'hFFFF_FFFC;
            rl = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rl = rl & 16'($urandom);
            run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   4'($urandom), rb, rl, $urandom_range(0, 1));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm_ldm_stm_sequencer.md
Name: sm_ldm_stm_sequencer

Overview:
- Multi-cycle initiator for ARM-style block transfers (LDM/STM).
- Walks a 16-bit register list in ascending order and drives the register file's read port (STM) or write port (LDM).
- Issues one word memory request per listed register over a req/ready handshake, then optionally writes back the updated base register.
- Sits between decode/control and the three-ported register file; stalls the core via busy.

Parameters:
DATA_WIDTH, 32, word/address width in bits
REG_COUNT, 16, register-list width; register index width is $clog2(REG_COUNT)=4

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
is_load  in  1  1=LDM, 0=STM
pre_index  in  1  P bit (before=1, after=0)
up  in  1  U bit (increment=1, decrement=0)
writeback  in  1  W bit
base_rn  in  4  base register index
base_addr  in  32  value of Rn at start
reg_list  in  16  bit i set = register i transferred
busy  out  1  high while operation in progress
done  out  1  one-cycle completion pulse
rf_read_adress  out  4  register read for STM data
rf_read_data  in  32  combinational register file read data (r15 returns PC+8)
rf_write_adress  out  4  write-port index
rf_write_data  out  32  write-port data
rf_write_enable  out  1  write-port enable
pc_write  out  1  load into r15 (write port not used for r15)
pc_value  out  32  new PC when pc_write=1
mem_req  out  1  memory request valid
mem_we  out  1  1=store
mem_addr  out  32  word address
mem_wdata  out  32  store data
mem_ready  in  1  request accepted/completed this cycle
mem_rdata  in  32  load data, valid when mem_req&&mem_ready

Behaviour:
- Reset (rst_n low, any time, including mid-operation): state IDLE; all outputs 0; latched operands cleared; no partial writeback.
- States: IDLE -> SETUP -> XFER -> WB -> DONE -> IDLE.
- IDLE: start=1 latches all inputs and goes to SETUP. start is ignored in every other state.
- SETUP (1 cycle): n = popcount(reg_list).
  - First address: IA=base, IB=base+4, DA=base-4n+4, DB=base-4n.
  - Writeback value: base+4n if up, else base-4n.
  - Arithmetic is modulo 2^32.
  - If n=0: skip to DONE, no memory access, no writeback.
- XFER:
  - Current register = lowest set bit of the remaining list.
  - mem_req=1; mem_we=!is_load; mem_addr, mem_we and mem_wdata are held stable until mem_ready.
  - STM: rf_read_adress=current; mem_wdata=rf_read_data.
  - A beat completes on a cycle with mem_req&&mem_ready:
    - LDM, current!=15: rf_write_enable=1, rf_write_adress=current, rf_write_data=mem_rdata.
    - LDM, current=15: pc_write=1, pc_value=mem_rdata.
    - Current bit is cleared; addr+=4.
    - Last beat goes to WB.
  - Back-to-back beats are allowed; with mem_ready tied high, n beats take n cycles.
- WB (1 cycle): rf_write_enable=1 to base_rn with the writeback value only if writeback=1 and NOT (is_load and reg_list[base_rn]); a loaded value wins. Otherwise idle cycle.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in SETUP, XFER, WB and DONE.
- Timing from start at cycle 0: first mem_req at cycle 2.
- rf_write_enable and pc_write are never both high.

Decomposition:
- Package sm_ldm_pkg:
  - state enum (IDLE, SETUP, XFER, WB, DONE)
  - WORD_BYTES=4
  - addressing-mode enum IA/IB/DA/DB derived from {pre_index, up}
- Sub-module sm_reg_list_scan: combinational lowest-set-bit priority encoder plus popcount over 16 bits.

Test Plan:
- STMIA, base=0x1000, list=0x0015, W=1, mem_ready=1 -> addresses 0x1000/0x1004/0x1008 carrying r0, r2, r4; WB writes r[Rn]=0x100C; done at cycle 6.
- LDMDB, base=0x2000, list=0x8003, mem_rdata=0xA, 0xB, 0xC -> addresses 0x1FF4, 0x1FF8, 0x1FFC; r0=0xA, r1=0xB; pc_write with 0xC; no rf write to index 15.
- LDMIA with Rn=1 in list and W=1 -> r1 gets the loaded value; no writeback write occurs in WB.
- mem_ready low for 3 cycles on beat 2 -> mem_addr/mem_wdata held constant; exactly one rf write per completed beat; start pulses during busy are ignored.
- reg_list=0 -> no mem_req; done 2 cycles after start (SETUP, DONE).
- rst_n asserted mid-XFER -> outputs 0 immediately; next start runs cleanly from the first register.
